// File: rtl/gppcu_instr_fetch.sv
// Instruction fetch unit.
// Streams INSTR_CNT words from instruction memory, starting at BASE_ADDR, into a
// 2-entry FIFO. The FIFO head goes to the decoder under a valid/ready handshake.
// Ports:
//   iCLK, iRST        clock, synchronous active-high reset
//   iSTART            start-program pulse, honoured only when idle
//   iBASE_ADDR        first instruction word address
//   iINSTR_CNT        number of instructions to fetch
//   oIMEM_RD          read strobe
//   oIMEM_ADDR        read address
//   iIMEM_DATA        read data, one cycle after oIMEM_RD
//   oOPC, oFIELDS     opcode / operand fields of the FIFO head
//   oVALID, iREADY    head handshake
//   oBUSY             program in progress
//   oDONE             one-cycle completion pulse
module gppcu_instr_fetch #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iSTART,
   input  logic [ADDR_W-1:0]  iBASE_ADDR,
   input  logic [ADDR_W:0]    iINSTR_CNT,
   output logic               oIMEM_RD,
   output logic [ADDR_W-1:0]  oIMEM_ADDR,
   input  logic [INSTR_W-1:0] iIMEM_DATA,
   output logic [4:0]         oOPC,
   output logic [INSTR_W-6:0] oFIELDS,
   output logic               oVALID,
   input  logic               iREADY,
   output logic               oBUSY,
   output logic               oDONE
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q;
   logic [ADDR_W:0]      rem_q;
   logic [INSTR_W-1:0]   fifo_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           count_q;
   logic                 inflight_q;
   logic                 done_q, done_d;

   logic                 push, pop, issue;
   logic [2:0]           pending;

   // Data returning from last cycle's read is always written.
   assign push = inflight_q;
   assign pop  = (count_q != 2'd0) && iREADY;

   // Counting a same-cycle pop as freed space keeps one transfer per cycle
   // with iREADY held high; the slot is still guaranteed when the data lands.
   assign pending = 3'(count_q) + 3'(inflight_q) - 3'(pop);
   assign issue   = (state_q == StRun) && (rem_q != '0) && (pending < 3'd2) && !iRST;

   // State register
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (iSTART) begin
               if (iINSTR_CNT != '0) state_d = StRun;
               else                  done_d  = 1'b1;
            end
         end
         StRun: begin
            if (issue && (rem_q == (ADDR_W+1)'(1))) state_d = StDrain;
         end
         StDrain: begin
            if ((count_q == 2'd0) && !inflight_q) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs; forced low while reset is asserted
   always_comb begin
      oIMEM_RD   = issue;
      oIMEM_ADDR = iRST ? '0 : pc_q;
      oVALID     = !iRST && (count_q != 2'd0);
      oOPC       = iRST ? '0 : fifo_q[rd_ptr_q][INSTR_W-1:INSTR_W-5];
      oFIELDS    = iRST ? '0 : fifo_q[rd_ptr_q][INSTR_W-6:0];
      oBUSY      = !iRST && (state_q != StIdle);
      oDONE      = !iRST && done_q;
   end

   // Datapath: PC / remaining count, read tracking, FIFO
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         pc_q       <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
      end else begin
         if ((state_q == StIdle) && iSTART) begin
            pc_q  <= iBASE_ADDR;
            rem_q <= iINSTR_CNT;
         end else if (issue) begin
            pc_q  <= pc_q + 1'b1;
            rem_q <= rem_q - 1'b1;
         end
         inflight_q <= issue;
         if (push) begin
            fifo_q[wr_ptr_q] <= iIMEM_DATA;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: doc/gppcu_instr_fetch.md
GPPCU_INSTR_FETCH -- requirements
Module: GPPCU_INSTR_FETCH

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 The block SHALL have parameter INSTR_W, default 32, instruction word width; opcode = bits [INSTR_W-1:INSTR_W-5].
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does (iCLK, iRST).
REQ-004 Ports, in order:
- iCLK  in  1  clock, all state on rising edge
- iRST  in  1  synchronous active-high reset
- iSTART  in  1  start-program pulse
- iBASE_ADDR  in  ADDR_W  first instruction address
- iINSTR_CNT  in  ADDR_W+1  number of instructions to fetch
- oIMEM_RD  out  1  instruction-memory read strobe
- oIMEM_ADDR  out  ADDR_W  read address
- iIMEM_DATA  in  INSTR_W  read data, valid exactly 1 cycle after oIMEM_RD
- oOPC  out  5  opcode of head instruction, to the decoder iOPC
- oFIELDS  out  INSTR_W-5  operand fields of head instruction
- oVALID  out  1  head instruction valid
- iREADY  in  1  downstream accepts head
- oBUSY  out  1  program in progress
- oDONE  out  1  one-cycle completion pulse

Function
REQ-005 The block SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-006 IDLE: iSTART=1 SHALL latch PC<=iBASE_ADDR and REM<=iINSTR_CNT; go to RUN if iINSTR_CNT!=0, else pulse oDONE next cycle and stay IDLE.
REQ-007 iSTART SHALL be ignored outside IDLE.
REQ-008 The block SHALL hold a 2-entry FIFO; a read SHALL issue (oIMEM_RD=1, oIMEM_ADDR=PC) in RUN only when occupancy + in-flight reads < 2.
REQ-009 Each issued read SHALL increment PC modulo 2^ADDR_W (wrap from all-ones to 0) and decrement REM.
REQ-010 RUN SHALL go to DRAIN in the cycle the read making REM=0 issues.
REQ-011 iIMEM_DATA SHALL be written into the FIFO in the cycle after each issued read, unconditionally (space guaranteed by REQ-008).
REQ-012 oVALID SHALL equal FIFO not-empty; oOPC/oFIELDS SHALL reflect the FIFO head and remain stable while oVALID=1 and iREADY=0.
REQ-013 A transfer SHALL occur when oVALID=1 and iREADY=1; it pops the head; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-014 With iREADY held high, the block SHALL sustain one transfer per cycle after the first.
REQ-015 First oVALID SHALL assert 3 cycles after iSTART is sampled (start edge -> read cycle -> data-capture cycle -> oVALID).
REQ-016 DRAIN: when FIFO empty and no read in flight, oDONE SHALL pulse for exactly one cycle and the FSM SHALL return to IDLE.
REQ-017 oBUSY SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-018 The block SHALL deliver instructions in strict address order, with no duplication or loss, regardless of the iREADY pattern.
REQ-019 Opcode values SHALL be passed through unmodified, including NOP and undefined codes.

Reset
REQ-020 On iRST=1, state SHALL go to IDLE; FIFO and in-flight flags cleared; PC=0, REM=0.
REQ-021 During reset, outputs SHALL be oIMEM_RD=0, oIMEM_ADDR=0, oVALID=0, oOPC=0, oFIELDS=0, oBUSY=0, oDONE=0.
REQ-022 iRST mid-program SHALL discard any data returning in the following cycle; no oDONE SHALL be produced for the aborted program.
REQ-023 iRST SHALL take priority over iSTART in the same cycle.

Verification
REQ-024 Base=0x010, cnt=4, iREADY=1 -> reads at 0x010..0x013 on consecutive cycles; 4 transfers in order; oVALID first 3 cycles after start; oDONE one pulse; oBUSY low after.
REQ-025 cnt=0 -> no oIMEM_RD; oDONE pulses once the cycle after start; oBUSY stays 0.
REQ-026 Base=0x3FE, cnt=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-027 cnt=8, iREADY random 50% -> never more than 2 entries buffered; head stable while stalled; all 8 delivered in order; exactly 1 oDONE.
REQ-028 iREADY=0 for 10 cycles after start -> exactly 2 reads issued, then stall; release -> remaining reads resume, no loss.
REQ-029 iRST asserted 1 cycle after a read issues -> all outputs 0 next cycle; returning data not visible; later start with new base runs cleanly.
